// File: rtl/alu_mdu_pipe.sv
// Execute-stage ALU with a LATENCY-deep result pipeline, HI/LO registers and an
// iterative one-bit-per-cycle multiply/divide unit sharing the output port.
module alu_mdu_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = 5,
  parameter int SHAMT_WIDTH  = 5,
  parameter int STATUS_WIDTH = 4,
  parameter int LATENCY      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   dataIn,
  input  logic [CTRL_WIDTH-1:0]     ctrl,
  input  logic [SHAMT_WIDTH-1:0]    shamt,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     dataOut,
  output logic [STATUS_WIDTH-1:0]   status,
  output logic                      mdu_busy
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(5'h00), OP_OR   = CTRL_WIDTH'(5'h01),
                                    OP_NOR  = CTRL_WIDTH'(5'h02), OP_XOR  = CTRL_WIDTH'(5'h03),
                                    OP_ADD  = CTRL_WIDTH'(5'h04), OP_SUB  = CTRL_WIDTH'(5'h05),
                                    OP_MULT = CTRL_WIDTH'(5'h06), OP_SLT  = CTRL_WIDTH'(5'h07),
                                    OP_SRL  = CTRL_WIDTH'(5'h08), OP_SLL  = CTRL_WIDTH'(5'h09),
                                    OP_SRA  = CTRL_WIDTH'(5'h0A), OP_MFHI = CTRL_WIDTH'(5'h0B),
                                    OP_MFLO = CTRL_WIDTH'(5'h0C), OP_MTHI = CTRL_WIDTH'(5'h0D),
                                    OP_MTLO = CTRL_WIDTH'(5'h0E), OP_SRLV = CTRL_WIDTH'(5'h0F),
                                    OP_SLLV = CTRL_WIDTH'(5'h10), OP_SRAV = CTRL_WIDTH'(5'h11),
                                    OP_MULTU= CTRL_WIDTH'(5'h12), OP_DIV  = CTRL_WIDTH'(5'h13),
                                    OP_DIVU = CTRL_WIDTH'(5'h14), OP_SLTU = CTRL_WIDTH'(5'h15);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic [3:0] make_status(input logic [W-1:0] r, input logic c, input logic v);
    return {v, c, r[W-1], ~|r};
  endfunction

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  state_t               state;
  logic [W-1:0]         a_u, b_u, hi_q, lo_q;
  logic signed [W-1:0]  a_s, b_s;
  logic                 accept, is_mdu, is_mul, signed_op, a_neg, b_neg;
  logic [W-1:0]         mag_a, mag_b;

  assign a_u       = dataIn[2*W-1:W];
  assign b_u       = dataIn[W-1:0];
  assign a_s       = signed'(a_u);
  assign b_s       = signed'(b_u);
  assign in_ready  = !mdu_busy && (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (ctrl == OP_MULT) || (ctrl == OP_MULTU);
  assign is_mdu    = is_mul || (ctrl == OP_DIV) || (ctrl == OP_DIVU);
  assign signed_op = (ctrl == OP_MULT) || (ctrl == OP_DIV);
  assign a_neg     = signed_op && a_u[W-1];
  assign b_neg     = signed_op && b_u[W-1];
  assign mag_a     = cond_neg(a_u, a_neg);
  assign mag_b     = cond_neg(b_u, b_neg);

  // single-cycle result, computed in the acceptance cycle
  logic [W-1:0] alu_res;
  logic [W:0]   sum, diff;
  logic         alu_c, alu_v;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = {1'b0, a_u} + {1'b0, b_u};
    diff    = {1'b0, a_u} - {1'b0, b_u};
    case (ctrl)
      OP_AND:  alu_res = a_u & b_u;
      OP_OR:   alu_res = a_u | b_u;
      OP_NOR:  alu_res = ~(a_u | b_u);
      OP_XOR:  alu_res = a_u ^ b_u;
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a_u[W-1] == b_u[W-1]) && (alu_res[W-1] != a_u[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (a_u[W-1] != b_u[W-1]) && (alu_res[W-1] != a_u[W-1]);
      end
      OP_SLT:  alu_res = {{(W-1){1'b0}}, a_s < b_s};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, a_u < b_u};
      OP_SRL:  alu_res = b_u >> shamt;
      OP_SLL:  alu_res = b_u << shamt;
      OP_SRA:  alu_res = b_s >>> shamt;
      OP_SRLV: alu_res = a_u >> b_u[SHAMT_WIDTH-1:0];
      OP_SLLV: alu_res = a_u << b_u[SHAMT_WIDTH-1:0];
      OP_SRAV: alu_res = a_s >>> b_u[SHAMT_WIDTH-1:0];
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // p0..p(LATENCY-1): single-cycle result pipeline
  logic              vld_p  [LATENCY];
  logic [W-1:0]      res_p  [LATENCY];
  logic [3:0]        stat_p [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        res_p[i]  <= '0;
        stat_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= accept && !is_mdu;
      res_p[0]  <= alu_res;
      stat_p[0] <= make_status(alu_res, alu_c, alu_v);
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        res_p[i]  <= res_p[i-1];
        stat_p[i] <= stat_p[i-1];
      end
    end
  end

  // MDU datapath: acc_hi is partial product / remainder, acc_lo is multiplier / quotient
  logic [W-1:0]     acc_hi, acc_lo, mag_b_q, a_raw;
  logic             mul_q, neg_lo_q, neg_hi_q, div0_q, ovf_q;
  logic [CNT_W-1:0] cnt;
  logic             mdu_vld;
  logic [W-1:0]     mdu_data;
  logic [3:0]       mdu_stat;
  logic [W:0]       mul_sum, div_sh, div_sub;
  logic             div_ge;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     fin_hi, fin_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b_q} : (W+1)'(0));
    div_sh   = {acc_hi, acc_lo[W-1]};
    div_ge   = div_sh >= {1'b0, mag_b_q};
    div_sub  = div_sh - {1'b0, mag_b_q};
    prod_fix = neg_lo_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (mul_q) begin
      fin_hi = prod_fix[2*W-1:W];
      fin_lo = prod_fix[W-1:0];
    end else begin
      fin_hi = div0_q ? a_raw : cond_neg(acc_hi, neg_hi_q);
      fin_lo = div0_q ? '1    : cond_neg(acc_lo, neg_lo_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mdu_busy <= 1'b0;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b_q  <= '0;
      a_raw    <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mdu_vld  <= 1'b0;
      mdu_data <= '0;
      mdu_stat <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      mdu_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && is_mdu) begin
            state    <= is_mul ? S_MUL : S_DIV;
            mdu_busy <= 1'b1;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            mag_b_q  <= mag_b;
            a_raw    <= a_u;
            mul_q    <= is_mul;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            div0_q   <= !is_mul && (b_u == '0);
            ovf_q    <= !is_mul && ((b_u == '0) ||
                        (signed_op && a_u == {1'b1, {(W-1){1'b0}}} && b_u == '1));
          end else if (accept && ctrl == OP_MTHI) begin
            hi_q <= a_u;
          end else if (accept && ctrl == OP_MTLO) begin
            lo_q <= a_u;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == CNT_W'(W)) begin
            // all bits consumed: sign fix-up lands in HI/LO as DONE is entered
            state    <= S_DONE;
            hi_q     <= fin_hi;
            lo_q     <= fin_lo;
            mdu_vld  <= 1'b1;
            mdu_data <= fin_lo;
            mdu_stat <= make_status(fin_lo, 1'b0, ovf_q);
          end else begin
            cnt <= cnt + 1'b1;
            if (state == S_MUL) begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
            end else begin
              acc_hi <= div_ge ? div_sub[W-1:0] : div_sh[W-1:0];
              acc_lo <= {acc_lo[W-2:0], div_ge};
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld_p[LATENCY-1] || mdu_vld;
  assign dataOut   = mdu_vld ? mdu_data : res_p[LATENCY-1];
  assign status    = STATUS_WIDTH'(mdu_vld ? mdu_stat : stat_p[LATENCY-1]);

endmodule

// File: doc/alu_mdu_pipe.md
Name: alu_mdu_pipe

Overview:
- Second-generation datapath ALU: parametrised width and output latency, with valid/ready input handshake and clocked HI/LO registers.
- Adds an iterative multiply/divide unit (MDU) with signed and unsigned multiply and divide.
- Replaces the single-cycle combinational ALU in the execute stage. Sits between operand fetch (upstream) and writeback (downstream).

Parameters:
- DATA_WIDTH, 32: operand, result, HI and LO width. Must be even and ≥ 8.
- CTRL_WIDTH, 5: opcode width.
- SHAMT_WIDTH, 5: immediate shift-amount width. Must equal clog2(DATA_WIDTH).
- STATUS_WIDTH, 4: status flags {overflow, carry, sign, zero}.
- LATENCY, 1: pipeline depth for single-cycle ops. Legal range 1..DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- dataIn  input  2*DATA_WIDTH  packed {A, B}; A = dataIn[2W-1:W], B = dataIn[W-1:0].
- ctrl  input  CTRL_WIDTH  opcode.
- shamt  input  SHAMT_WIDTH  immediate shift amount.
- out_valid  output  1  one-cycle pulse; dataOut and status are valid.
- dataOut  output  DATA_WIDTH  result.
- status  output  STATUS_WIDTH  [0] zero, [1] sign, [2] carry/borrow, [3] overflow.
- mdu_busy  output  1  MDU iterating.

Behaviour:
- Reset: synchronous, active-high. Clears HI, LO, all pipeline registers, out_valid, dataOut, status and mdu_busy. FSM goes to IDLE. After reset, in_ready=1.
- Handshake: an operation is accepted when in_valid && in_ready.
  - in_ready = !mdu_busy && FSM in IDLE.
  - No output backpressure.
  - Results leave in acceptance order.
- Single-cycle opcodes. Result appears LATENCY cycles after acceptance, with out_valid=1 for one cycle.
  - 0x00 and, 0x01 or, 0x02 nor, 0x03 xor.
  - 0x04 add; 0x05 sub (A−B).
  - 0x07 slt signed; 0x15 sltu.
  - 0x08 srl B by shamt; 0x09 sll B by shamt; 0x0A sra B by shamt.
  - 0x0F srl A by B[SHAMT_WIDTH-1:0]; 0x10 sll; 0x11 sra.
  - 0x0B mfhi, 0x0C mflo: read HI/LO as registered at acceptance.
  - 0x0D mthi, 0x0E mtlo: write HI/LO at the acceptance edge; dataOut=0, out_valid still pulses.
  - Undefined opcodes: dataOut=0, out_valid pulses.
- Flags:
  - zero = (dataOut==0); sign = dataOut[W-1].
  - carry = add carry-out, or sub borrow (A<B unsigned); 0 for all other ops.
  - overflow (add) = A/B signs equal and result sign differs.
  - overflow (sub) = A/B signs differ and result sign differs from A.
  - overflow is 0 for other ops except divide (below).
- MDU opcodes: 0x06 mult signed, 0x12 multu, 0x13 div signed, 0x14 divu.
  - FSM IDLE→MUL or IDLE→DIV on acceptance. Operands are converted to magnitudes and the sign is latched.
  - Iteration: one bit per cycle, DATA_WIDTH cycles. MUL = shift-add. DIV = restoring.
  - After the last iteration: DONE (sign fix-up, HI/LO write) → IDLE.
  - out_valid pulses exactly DATA_WIDTH+2 cycles after the acceptance edge. dataOut = LO, flags from LO, carry=0.
  - mdu_busy = 1 from the cycle after acceptance through the DONE cycle.
  - Because LATENCY ≤ DATA_WIDTH, earlier single-cycle results always drain first. A single-cycle result and an MDU result never collide.
- Multiply: {HI,LO} = full 2W product.
- Divide: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - Divide by zero: LO = all ones, HI = A, status[3]=1. Still DATA_WIDTH+2 latency.
  - Signed MIN / −1: LO = MIN, HI = 0, status[3]=1.
- Reset mid-MDU: the operation is aborted, HI/LO=0, no out_valid. in_ready=1 in the cycle after the reset cycle.
- in_valid while in_ready=0: ignored, not queued. Upstream must hold it.

Test Plan:
- add A=0x7FFFFFFF, B=0x00000001, LATENCY=1 → next cycle out_valid=1, dataOut=0x80000000, status=4'b1010. Then sub A=0, B=1 → dataOut=0xFFFFFFFF, status=4'b0110.
- mult A=0xFFFFFFFD (−3), B=7 → in_ready=0 for 34 cycles; out_valid at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB. Follow with mfhi → 0xFFFFFFFF and mflo → 0xFFFFFFEB. Then multu with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- div A=7, B=0xFFFFFFFE (−2) → LO=0xFFFFFFFD, HI=1, overflow=0. divu A=100, B=0 → LO=0xFFFFFFFF, HI=100, status[3]=1. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0, status[3]=1.
- LATENCY=4: issue back-to-back and, sll (B=1, shamt=31), then mult (2,3), then an or held while busy. Expect:
  - out_valid order: and, sll=0x80000000, LO=6, or.
  - in_ready=0 during the MDU run.
  - The or is accepted on the first in_ready=1 cycle.
- Assert rst for one cycle at MDU iteration 10 → no out_valid; HI=LO=0; in_ready=1 on the next cycle. A following mflo → 0.
- mthi 0x12345678 then mfhi in the next accepted cycle → 0x12345678. sra B=0x80000000, shamt=4 → 0xF8000000, status=4'b0010.
